// File: rtl/phy_pkg.sv
// Shared constants and types for the Phy link controller.
//   COM_SYM / IDLE_SYM : training symbols exchanged during bring-up
//   link_state_t       : controller state, also exported on the debug port
//   tx_mode_t          : transmitter source select
package phy_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = $clog2(NUM_LANES);
    localparam int unsigned SYM_W     = 8;

    localparam logic [SYM_W-1:0] COM_SYM  = 8'hBC;
    localparam logic [SYM_W-1:0] IDLE_SYM = 8'h7C;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_SYNC   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } link_state_t;

    typedef enum logic [1:0] {
        TX_OFF  = 2'b00,
        TX_COM  = 2'b01,
        TX_IDLE = 2'b10,
        TX_DATA = 2'b11
    } tx_mode_t;

endpackage

// File: rtl/phy_rr_arbiter.sv
// Registered 4-way round-robin arbiter for the shared transmit slot.
// Ports:
//   clk_f, reset : clock, async active-low reset
//   en           : arbitrate this edge; when low grant clears, pointer and sel hold
//   req          : per-lane requests
//   grant        : registered one-hot grant (or 0)
//   sel          : index of the last granted lane
module phy_rr_arbiter
    import phy_pkg::*;
(
    input  logic                 clk_f,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NUM_LANES-1:0] req,
    output logic [NUM_LANES-1:0] grant,
    output logic [LANE_W-1:0]    sel
);

    logic [LANE_W-1:0]    ptr_q, ptr_d;
    logic [LANE_W-1:0]    sel_q, sel_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic [LANE_W-1:0]    idx;
    logic                 found;

    // Search starts one past the last winner; lane index wraps mod NUM_LANES.
    always_comb begin
        grant_d = '0;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        idx     = '0;
        found   = 1'b0;
        if (en) begin
            for (int unsigned i = 1; i <= NUM_LANES; i++) begin
                idx = LANE_W'(32'(ptr_q) + i);
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    grant_d[idx] = 1'b1;
                    ptr_d        = idx;
                    sel_d        = idx;
                end
            end
        end
    end

    // Pointer starts at the top lane so lane 0 wins the first arbitration.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            ptr_q   <= LANE_W'(NUM_LANES - 1);
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;

endmodule

// File: rtl/phy_link_ctrl.sv
// Link bring-up controller and lane scheduler for the 4-lane serial Phy.
// Ports:
//   clk_f, reset      : clock, async active-low reset
//   start             : link enable, low forces RESET
//   rx_valid, rx_data : recovered receive byte stream
//   req               : per-lane transmit requests
//   grant, sel        : registered round-robin grant and its lane index
//   tx_mode           : transmitter source (off / COM / IDLE / lane data)
//   active, error     : link up / sticky training failure
//   state             : current state for debug
module phy_link_ctrl
    import phy_pkg::*;
#(
    parameter int unsigned COM_COUNT  = 4,
    parameter int unsigned IDLE_COUNT = 2,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned LOSS       = 8
) (
    input  logic                 clk_f,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [SYM_W-1:0]     rx_data,
    input  logic [NUM_LANES-1:0] req,
    output logic [NUM_LANES-1:0] grant,
    output logic [LANE_W-1:0]    sel,
    output logic [1:0]           tx_mode,
    output logic                 active,
    output logic                 error,
    output logic [2:0]           state
);

    localparam int unsigned COM_W   = $clog2(COM_COUNT) + 1;
    localparam int unsigned IDLE_W  = $clog2(IDLE_COUNT) + 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY) + 1;
    localparam int unsigned LOSS_W  = $clog2(LOSS) + 1;

    link_state_t        state_q, state_d;
    tx_mode_t           tx_mode_q, tx_mode_d;
    logic               active_q, active_d;
    logic               error_q, error_d;
    logic [COM_W-1:0]   com_cnt_q, com_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_cnt_q, loss_cnt_d;

    logic com_hit, idle_hit, com_lock, idle_lock, timeout, last_try, lost;
    logic arb_en;

    assign com_hit   = rx_valid && (rx_data == COM_SYM);
    assign idle_hit  = rx_valid && (rx_data == IDLE_SYM);
    // Lock is judged on the byte that would complete the run, so the state
    // change lands on the same edge that samples it.
    assign com_lock  = com_hit && (com_cnt_q == COM_W'(COM_COUNT - 1));
    assign idle_lock = idle_hit && (idle_cnt_q == IDLE_W'(IDLE_COUNT - 1));
    assign timeout   = (timer_q == TIMER_W'(TIMEOUT - 1));
    assign last_try  = (retry_q == RETRY_W'(MAX_RETRY - 1));
    assign lost      = !rx_valid && (loss_cnt_q == LOSS_W'(LOSS - 1));

    // Next state, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        idle_cnt_d = idle_cnt_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        loss_cnt_d = loss_cnt_q;
        tx_mode_d  = TX_OFF;
        active_d   = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                com_cnt_d  = '0;
                idle_cnt_d = '0;
                timer_d    = '0;
                retry_d    = '0;
                loss_cnt_d = '0;
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (com_hit) begin
                    if (com_cnt_q != '1) com_cnt_d = com_cnt_q + 1'b1;
                end else if (rx_valid) begin
                    com_cnt_d = '0;
                end
                if (com_lock) begin
                    state_d    = ST_IDLE;
                    com_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else if (timeout) begin
                    timer_d   = '0;
                    com_cnt_d = '0;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                    if (last_try) state_d = ST_ERROR;
                end
            end
            ST_IDLE: begin
                // Timer keeps running: IDLE exchange is part of the same attempt.
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (idle_hit) begin
                    if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
                end else if (rx_valid && !com_hit) begin
                    idle_cnt_d = '0;
                end
                if (idle_lock) begin
                    state_d    = ST_ACTIVE;
                    retry_d    = '0;
                    timer_d    = '0;
                    idle_cnt_d = '0;
                    loss_cnt_d = '0;
                end else if (timeout) begin
                    timer_d    = '0;
                    com_cnt_d  = '0;
                    idle_cnt_d = '0;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                    state_d = last_try ? ST_ERROR : ST_SYNC;
                end
            end
            ST_ACTIVE: begin
                if (!rx_valid) begin
                    if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
                end else begin
                    loss_cnt_d = '0;
                end
                if (lost) begin
                    state_d    = ST_SYNC;
                    timer_d    = '0;
                    com_cnt_d  = '0;
                    loss_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Dropping the enable wins over every other transition.
        if (!start) begin
            state_d    = ST_RESET;
            com_cnt_d  = '0;
            idle_cnt_d = '0;
            timer_d    = '0;
            retry_d    = '0;
            loss_cnt_d = '0;
        end

        // The arbiter always grants when any lane requests, so |req predicts grant.
        case (state_d)
            ST_SYNC:   tx_mode_d = TX_COM;
            ST_IDLE:   tx_mode_d = TX_IDLE;
            ST_ACTIVE: tx_mode_d = (|req) ? TX_DATA : TX_IDLE;
            default:   tx_mode_d = TX_OFF;
        endcase
        active_d = (state_d == ST_ACTIVE);
        error_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            tx_mode_q  <= TX_OFF;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
            com_cnt_q  <= '0;
            idle_cnt_q <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_mode_q  <= tx_mode_d;
            active_q   <= active_d;
            error_q    <= error_d;
            com_cnt_q  <= com_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // Grant is produced on the same edge the link enters or stays in ACTIVE.
    assign arb_en = (state_d == ST_ACTIVE);

    phy_rr_arbiter u_arb (
        .clk_f (clk_f),
        .reset (reset),
        .en    (arb_en),
        .req   (req),
        .grant (grant),
        .sel   (sel)
    );

    assign tx_mode = tx_mode_q;
    assign active  = active_q;
    assign error   = error_q;
    assign state   = state_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Bench for phy_link_ctrl: table-driven bring-up/arbitration/loss vectors,
// hand-written corner sequences, and random traffic against a behavioural model.
module tb_phy_link_ctrl;

    localparam int COM_COUNT  = 4;
    localparam int IDLE_COUNT = 2;
    localparam int TIMEOUT    = 64;
    localparam int MAX_RETRY  = 3;
    localparam int LOSS       = 8;

    logic       clk_f;
    logic       reset;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [1:0] tx_mode;
    logic       active;
    logic       error;
    logic [2:0] state;

    phy_link_ctrl #(
        .COM_COUNT  (COM_COUNT),
        .IDLE_COUNT (IDLE_COUNT),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRY  (MAX_RETRY),
        .LOSS       (LOSS)
    ) dut (
        .clk_f    (clk_f),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .tx_mode  (tx_mode),
        .active   (active),
        .error    (error),
        .state    (state)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: link states as plain integers 0..4, counters as ints.
    int       m_state, m_com, m_idle, m_timer, m_retry, m_loss, m_last, m_sel, m_tx;
    bit [3:0] m_grant;

    function automatic void model_reset();
        m_state = 0; m_com = 0; m_idle = 0; m_timer = 0; m_retry = 0; m_loss = 0;
        m_last = 3; m_sel = 0; m_tx = 0; m_grant = 4'h0;
    endfunction

    function automatic void model_edge(bit st, bit v, bit [7:0] d, bit [3:0] r);
        int  ns;
        bit  com, idl, tmo;
        com = v && (d == 8'hBC);
        idl = v && (d == 8'h7C);
        tmo = (m_timer == TIMEOUT - 1);
        ns  = m_state;
        case (m_state)
            0: begin
                m_com = 0; m_idle = 0; m_timer = 0; m_retry = 0; m_loss = 0;
                if (st) ns = 1;
            end
            1: begin
                m_timer++;
                if (com) m_com++; else if (v) m_com = 0;
                if (m_com == COM_COUNT) begin
                    ns = 2; m_com = 0; m_idle = 0;
                end else if (tmo) begin
                    m_timer = 0; m_com = 0; m_retry++;
                    if (m_retry == MAX_RETRY) ns = 4;
                end
            end
            2: begin
                m_timer++;
                if (idl) m_idle++; else if (v && !com) m_idle = 0;
                if (m_idle == IDLE_COUNT) begin
                    ns = 3; m_retry = 0; m_timer = 0; m_idle = 0; m_loss = 0;
                end else if (tmo) begin
                    m_timer = 0; m_com = 0; m_idle = 0; m_retry++;
                    ns = (m_retry == MAX_RETRY) ? 4 : 1;
                end
            end
            3: begin
                if (!v) m_loss++; else m_loss = 0;
                if (m_loss == LOSS) begin
                    ns = 1; m_timer = 0; m_com = 0; m_loss = 0;
                end
            end
            default: ;
        endcase
        if (!st) begin
            ns = 0; m_com = 0; m_idle = 0; m_timer = 0; m_retry = 0; m_loss = 0;
        end
        m_grant = 4'h0;
        if (ns == 3) begin
            for (int off = 1; off <= 4; off++) begin
                int lane;
                lane = (m_last + off) % 4;
                if (m_grant == 4'h0 && r[lane]) begin
                    m_grant[lane] = 1'b1;
                    m_last = lane;
                    m_sel  = lane;
                end
            end
        end
        case (ns)
            1:       m_tx = 1;
            2:       m_tx = 2;
            3:       m_tx = (m_grant != 4'h0) ? 3 : 2;
            default: m_tx = 0;
        endcase
        m_state = ns;
    endfunction

    function automatic int dut_outs();
        return int'({state, tx_mode, active, error, grant, sel});
    endfunction

    function automatic int model_outs();
        return int'({3'(m_state), 2'(m_tx), (m_state == 3), (m_state == 4), m_grant, 2'(m_sel)});
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, compare after it.
    task automatic step(input bit st, input bit v, input bit [7:0] d, input bit [3:0] r);
        start = st; rx_valid = v; rx_data = d; req = r;
        @(posedge clk_f);
        model_edge(st, v, d, r);
        #1;
        check("model_outs", dut_outs(), model_outs());
    endtask

    task automatic bring_up();
        step(1'b0, 1'b0, 8'h00, 4'h0);
        step(1'b1, 1'b0, 8'h00, 4'h0);
        repeat (COM_COUNT) step(1'b1, 1'b1, 8'hBC, 4'h0);
        repeat (IDLE_COUNT) step(1'b1, 1'b1, 8'h7C, 4'h0);
    endtask

    typedef struct {
        bit       st;
        bit       v;
        bit [7:0] d;
        bit [3:0] r;
        int       e_state;
        int       e_tx;
        bit       e_act;
        bit [3:0] e_grant;
        int       e_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit st, bit v, bit [7:0] d, bit [3:0] r,
                                int es, int et, bit ea, bit [3:0] eg, int esel);
        vec_t x;
        x.st = st; x.v = v; x.d = d; x.r = r;
        x.e_state = es; x.e_tx = et; x.e_act = ea; x.e_grant = eg; x.e_sel = esel;
        vecs.push_back(x);
    endfunction

    initial begin
        bit [7:0] align_seq [7];
        int       err_cyc;

        // Clean bring-up, rotation, lane drop, loss of link, re-bring-up.
        add(1, 0, 8'h00, 4'h0, 1, 1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 8'hBC, 4'h0, 1, 1, 0, 4'h0, 0);
        add(1, 1, 8'hBC, 4'h0, 2, 2, 0, 4'h0, 0);
        add(1, 1, 8'h7C, 4'h0, 2, 2, 0, 4'h0, 0);
        add(1, 1, 8'h7C, 4'h0, 3, 2, 1, 4'h0, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 8'h00, 4'hF, 3, 3, 1, 4'(1 << (i % 4)), i % 4);
        for (int i = 0; i < 4; i++) add(1, 1, 8'h00, 4'h5, 3, 3, 1, (i % 2 == 0) ? 4'h1 : 4'h4, (i % 2) * 2);
        add(1, 1, 8'h00, 4'h0, 3, 2, 1, 4'h0, 2);
        for (int i = 0; i < 7; i++) add(1, 0, 8'h00, 4'h2, 3, 3, 1, 4'h2, 1);
        add(1, 0, 8'h00, 4'h2, 1, 1, 0, 4'h0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 8'hBC, 4'h0, 1, 1, 0, 4'h0, 1);
        add(1, 1, 8'hBC, 4'h0, 2, 2, 0, 4'h0, 1);
        add(1, 1, 8'h7C, 4'h0, 2, 2, 0, 4'h0, 1);
        add(1, 1, 8'h7C, 4'h0, 3, 2, 1, 4'h0, 1);
        add(1, 1, 8'h00, 4'hF, 3, 3, 1, 4'h4, 2);

        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; req = 4'h0;
        model_reset();
        repeat (2) @(posedge clk_f);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_sel", int'(sel), 0);
        check("reset_txmode", int'(tx_mode), 0);
        check("reset_active", int'(active), 0);
        check("reset_error", int'(error), 0);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00, 4'h0);
        check("idle_in_reset", int'(state), 0);

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].v, vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
            check($sformatf("vec%0d_txmode", i), int'(tx_mode), vecs[i].e_tx);
            check($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].e_act));
            check($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].e_grant));
            check($sformatf("vec%0d_sel", i), int'(sel), vecs[i].e_sel);
        end

        // Broken alignment: the 0x55 restarts the COM run.
        align_seq = '{8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        step(1'b0, 1'b0, 8'h00, 4'h0);
        step(1'b1, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, align_seq[i], 4'h0);
            check($sformatf("align%0d_state", i), int'(state), (i == 6) ? 2 : 1);
        end
        // COM during IDLE neither counts nor clears the IDLE run.
        step(1'b1, 1'b1, 8'h7C, 4'h0);
        check("idle_com_a", int'(state), 2);
        step(1'b1, 1'b1, 8'hBC, 4'h0);
        check("idle_com_b", int'(state), 2);
        step(1'b1, 1'b1, 8'h7C, 4'h0);
        check("idle_com_c", int'(state), 3);

        // start=0 on the same edge as the COM lock wins.
        step(1'b0, 1'b0, 8'h00, 4'h0);
        step(1'b1, 1'b0, 8'h00, 4'h0);
        repeat (3) step(1'b1, 1'b1, 8'hBC, 4'h0);
        step(1'b0, 1'b1, 8'hBC, 4'h0);
        check("lock_vs_stop", int'(state), 0);

        // Timeout path: three attempts then ERROR at cycle 193.
        err_cyc = -1;
        for (int c = 1; c <= 300 && err_cyc < 0; c++) begin
            step(1'b1, 1'b0, 8'h00, 4'h0);
            if (error === 1'b1) err_cyc = c;
            else if (c == 192) check("pre_error_state", int'(state), 1);
        end
        check("error_cycle", err_cyc, 193);
        check("error_state", int'(state), 4);
        check("error_txmode", int'(tx_mode), 0);
        step(1'b1, 1'b1, 8'hBC, 4'h0);
        check("error_sticky", int'(error), 1);
        step(1'b0, 1'b0, 8'h00, 4'h0);
        check("error_exit_state", int'(state), 0);
        check("error_exit_flag", int'(error), 0);

        // Async reset between edges while granting.
        bring_up();
        repeat (3) step(1'b1, 1'b1, 8'h00, 4'hF);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_state", int'(state), 0);
        check("arst_grant", int'(grant), 0);
        check("arst_sel", int'(sel), 0);
        check("arst_txmode", int'(tx_mode), 0);
        check("arst_active", int'(active), 0);
        check("arst_error", int'(error), 0);
        #1;
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h00, 4'h0);
        check("arst_resync", int'(state), 1);
        bring_up();
        step(1'b1, 1'b1, 8'h00, 4'hF);
        check("arst_first_grant", int'(grant), 1);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit       st;
            bit       v;
            bit [7:0] d;
            st = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0, 1:    d = 8'hBC;
                2:       d = 8'h7C;
                default: d = 8'($urandom);
            endcase
            step(st, v, d, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/phy_link_ctrl.md
# phy_link_ctrl

Link bring-up controller and lane scheduler for the 4-lane serial Phy. It sequences the transmit side through COM (0xBC) alignment and IDLE (0x7C) exchange until the receive side confirms lock, then raises `active`. While active, it shares the single serial transmit slot between the four lane requesters with a registered round-robin grant. It sits between the lane FIFOs/valid sources and the Phy transmitter, and observes the Phy receiver's recovered byte stream.

## Interface
- `COM_COUNT`, 4: consecutive received COM symbols required to leave SYNC.
- `IDLE_COUNT`, 2: consecutive received IDLE symbols required to enter ACTIVE.
- `TIMEOUT`, 64: cycles allowed per SYNC attempt.
- `MAX_RETRY`, 3: failed SYNC attempts tolerated before ERROR.
- `LOSS`, 8: consecutive cycles with `rx_valid`=0 in ACTIVE that count as loss of link.

- `clk_f`  in  1  sole clock; all flops on its rising edge.
- `reset`  in  1  asynchronous, active-low; flops clear immediately when low.
- `start`  in  1  link enable; 0 forces RESET from any state.
- `rx_valid`  in  1  received byte valid this cycle.
- `rx_data`  in  8  received byte.
- `req`  in  4  per-lane data request (lane i = bit i).
- `grant`  out  4  one-hot grant, or 0.
- `sel`  out  2  encoded index of granted lane; holds its last value when `grant`=0.
- `tx_mode`  out  2  00 off, 01 send COM, 10 send IDLE, 11 send granted lane data.
- `active`  out  1  link up (state ACTIVE).
- `error`  out  1  sticky training failure (state ERROR).
- `state`  out  3  current state, for debug.

## Operation
- States: RESET=0, SYNC=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET: `tx_mode`=00, all counters cleared. `start`=1 → SYNC.
- SYNC: `tx_mode`=01. `com_cnt` increments on `rx_valid`&&`rx_data`==0xBC. It clears on any other valid byte and holds when `rx_valid`=0. When `com_cnt` reaches `COM_COUNT`, go to IDLE. `timer` increments every cycle. When `timer`==`TIMEOUT`-1 without lock: `retry`++, and `timer` and `com_cnt` clear. If that was attempt `MAX_RETRY`, go to ERROR instead. Lock and timeout on the same cycle: lock wins.
- IDLE: `tx_mode`=10. `idle_cnt` counts consecutive valid 0x7C; it holds on `rx_valid`=0. Valid 0xBC is ignored (the peer is still aligning). Any other valid byte clears `idle_cnt`. When `idle_cnt` reaches `IDLE_COUNT`, go to ACTIVE and clear `retry`. The SYNC timer also runs here; timeout → SYNC, with retry accounting as in SYNC.
- ACTIVE: `active`=1. Round-robin arbiter: the search starts at lane (last granted + 1) mod 4. Pointer resets to lane 3, so lane 0 wins first. The winner's `grant` is registered and `tx_mode`=11. When no request exists, `grant`=0 and `tx_mode`=10. A granted lane holds for exactly one cycle, then re-arbitrates; continuous requests rotate 0,1,2,3,0,… `loss_cnt` counts consecutive `rx_valid`=0 cycles. When it reaches `LOSS`, go to SYNC, with `grant`=0 and the arbiter pointer preserved.
- ERROR: `error`=1, `tx_mode`=00. Exit only to RESET, via `start`=0.
- `start`=0 overrides every transition, including the same-cycle lock.
- Counter widths: `$clog2(param)+1`, saturating; no wrap.

## Timing
- Every output is registered.
- Reset values:
  - `state`=RESET
  - `grant`=0
  - `sel`=0
  - `tx_mode`=00
  - `active`=0
  - `error`=0
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N. `state` and `tx_mode` change together.
- The COM lock decision uses the byte sampled at the edge where `com_cnt` would reach `COM_COUNT`. `state`=IDLE is visible after that same edge.
- Grant latency: `req` at edge N → `grant` after edge N. Dropping `req` at edge N removes the grant after edge N; there are no zombie grants.
- Async reset mid-operation: all state clears in zero cycles. After deassertion, SYNC is re-entered one edge after `start`=1 is sampled.

## Structure
- Package `phy_pkg`:
  - symbol constants `COM_SYM`=8'hBC and `IDLE_SYM`=8'h7C;
  - state enum `link_state_t`;
  - `tx_mode_t` encodings.
- Sub-module `phy_rr_arbiter`: 4-way round-robin with `clk_f`, `reset`, `en`, `req[3:0]`, `grant[3:0]`, `sel[1:0]`. It holds its pointer while `en`=0.
- The top level holds the FSM, counters and output registers.

## Test plan
- Clean bring-up: `start`=1, then feed 4×0xBC then 2×0x7C → `state` goes 1 then 2 then 3, `active`=1, `tx_mode` goes 01, then 10, then 10 with no req.
- Broken alignment: feed 0xBC,0xBC,0x55,0xBC×4 → lock only after the final fourth 0xBC, with no timeout.
- Timeout/error: `rx_valid`=0 forever → three 64-cycle attempts, then `error`=1 at cycle 193, `tx_mode`=00. `start`=0 → RESET.
- Arbitration: in ACTIVE with `req`=4'b1111 for 8 cycles → `grant` sequence 1,2,4,8,1,2,4,8 and `sel` 0,1,2,3,…. Then `req`=4'b0101 → 1,4,1,4.
- Loss: in ACTIVE, hold `rx_valid`=0 for 8 cycles → `state`=SYNC, `grant`=0, `active`=0 after the 8th edge.
- Async reset: assert `reset`=0 mid-ACTIVE between edges → all outputs at reset values immediately, with no clock edge needed.
